// File: rtl/ntt_pkg.sv
// Shared NTT definitions: pointwise-pass FSM encoding, reduction selectors and
// elaboration-time helpers for the Montgomery constants.
package ntt_pkg;

  localparam int unsigned SIMPLE     = 0;
  localparam int unsigned BARRETT    = 1;
  localparam int unsigned MONTGOMERY = 2;

  typedef logic [1:0] pw_state_t;

  localparam pw_state_t IDLE  = 2'd0;
  localparam pw_state_t RUN   = 2'd1;
  localparam pw_state_t DRAIN = 2'd2;
  localparam pw_state_t DONE  = 2'd3;

  // -q^-1 mod 2^128 by Newton iteration; odd q is its own inverse mod 8.
  function automatic logic [127:0] mont_neg_inv(input logic [127:0] q);
    logic [127:0] x;
    x = q;
    for (int i = 0; i < 6; i++) begin
      x = x * (128'd2 - q * x);
    end
    return ~x + 128'd1;
  endfunction

  // 2^e mod q by repeated doubling.
  function automatic logic [63:0] pow2_mod(input int unsigned e, input logic [63:0] q);
    logic [63:0] r;
    r = (q == 64'd1) ? 64'd0 : 64'd1;
    for (int unsigned i = 0; i < e; i++) begin
      r = r << 1;
      if (r >= q) r = r - q;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_pw_ctrl_mod_mult.sv
// Combinational modular multiplier p = (a*b) mod Q. REDUCTION_TYPE selects the
// reduction datapath; all three return the plain residue in [0, Q-1].
module mod_mult
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int unsigned REDUCTION_TYPE = BARRETT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod;
  assign prod = PW'(a) * PW'(b);

  if (REDUCTION_TYPE == SIMPLE) begin : g_simple
    assign p = WIDTH'(prod % PW'(Q));
  end else if (REDUCTION_TYPE == MONTGOMERY) begin : g_mont
    localparam logic [PW-1:0] QW   = PW'(Q);
    localparam logic [PW-1:0] QINV = PW'(mont_neg_inv(128'(Q)));
    localparam logic [PW-1:0] R2   = PW'(pow2_mod(2 * PW, 64'(Q)));

    logic [2*PW:0] s1, s2;
    logic [PW-1:0] m1, m2, t1, t2, x2;

    // R = 2^PW exceeds any product; the second REDC with R^2 mod Q cancels the R^-1.
    always_comb begin
      m1 = prod * QINV;
      s1 = ((2*PW+1)'(prod) + (2*PW+1)'(m1) * (2*PW+1)'(QW)) >> PW;
      t1 = PW'(s1);
      if (t1 >= QW) t1 = t1 - QW;
      x2 = t1 * R2;
      m2 = x2 * QINV;
      s2 = ((2*PW+1)'(x2) + (2*PW+1)'(m2) * (2*PW+1)'(QW)) >> PW;
      t2 = PW'(s2);
      if (t2 >= QW) t2 = t2 - QW;
      p = WIDTH'(t2);
    end
  end else begin : g_barrett
    localparam logic [PW:0]   QB = (PW+1)'(Q);
    localparam logic [PW-1:0] QR = PW'(Q);
    localparam logic [PW:0]   MU = {1'b1, {PW{1'b0}}} / QB;

    logic [2*PW+1:0] qm;
    logic [PW:0]     qest;
    logic [PW-1:0]   r;

    // Quotient estimate undershoots by at most two, hence two corrections.
    always_comb begin
      qm   = (2*PW+2)'(prod) * (2*PW+2)'(MU);
      qest = (PW+1)'(qm >> PW);
      r    = prod - PW'(qest * QB);
      if (r >= QR) r = r - QR;
      if (r >= QR) r = r - QR;
      p = WIDTH'(r);
    end
  end

endmodule

// File: rtl/ntt_pw_ctrl.sv
// Pointwise NTT pass controller: streams N coefficient pairs through one shared
// mod_mult and writes C[i] two cycles after each read. NTT_PW_ACCUM_EN adds accumulate.
module ntt_pw_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned N              = 256,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned Q              = 3329,
  parameter int unsigned REDUCTION_TYPE = BARRETT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
`ifdef NTT_PW_ACCUM_EN
  input  logic                 accum,
  input  logic [WIDTH-1:0]     rd_data_c,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data_a,
  input  logic [WIDTH-1:0]     rd_data_b,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data
);

  localparam int unsigned   AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  pw_state_t        state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             drain_q, drain_d;
  logic             flush;
  logic [1:0]       valid_q;
  logic [AW-1:0]    addr1_q, addr2_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] result;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          // N is a power of two, so idx wraps back to 0 on the last issue.
          idx_d = idx_q + AW'(1);
          if (idx_q == LAST) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
          if (drain_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mod_mult #(
    .WIDTH         (WIDTH),
    .Q             (Q),
    .REDUCTION_TYPE(REDUCTION_TYPE)
  ) u_mod_mult (
    .a(rd_data_a),
    .b(rd_data_b),
    .p(prod)
  );

`ifdef NTT_PW_ACCUM_EN
  localparam logic [WIDTH:0] QS = (WIDTH+1)'(Q);

  logic           accum_q;
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, rd_data_c} + {1'b0, prod};
    if (sum >= QS) sum = sum - QS;
    result = accum_q ? WIDTH'(sum) : prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      accum_q <= accum;
    end
  end
`else
  assign result = prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
      valid_q <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      // Abort drops every read still in flight.
      valid_q <= {valid_q[0] & ~flush, rd_en & ~flush};
      addr1_q <= idx_q;
      addr2_q <= addr1_q;
      if (valid_q[0]) wdata_q <= result;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == RUN);
  assign rd_addr = idx_q;
  assign wr_en   = valid_q[1];
  assign wr_addr = addr2_q;
  assign wr_data = wdata_q;

endmodule

// File: tb/tb_ntt_pw_ctrl.sv
// Bench for ntt_pw_ctrl with N=4: one instance per reduction type sharing one memory model.
// Define NTT_PW_ACCUM_EN to also exercise the accumulate path.
module tb_ntt_pw_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned Q  = 3329;
  localparam int          ND = 3;
  localparam int          NV = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [31:0] rd_a = '0;
  logic [31:0] rd_b = '0;
`ifdef NTT_PW_ACCUM_EN
  logic        accum_in = 1'b0;
  logic [31:0] rd_c = '0;
`endif

  logic [ND-1:0] busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr [ND];
  logic [AW-1:0] wr_addr [ND];
  logic [31:0]   wr_data [ND];

  logic [31:0] mem_a [N];
  logic [31:0] mem_b [N];
  logic [31:0] mem_c [N];
  logic [31:0] exp_data [N];
  vec_t        tbl [NV];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ntt_pw_ctrl #(
      .N(N), .WIDTH(32), .Q(Q), .REDUCTION_TYPE(g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
`ifdef NTT_PW_ACCUM_EN
      .accum    (accum_in),
      .rd_data_c(rd_c),
`endif
      .busy     (busy[g]),
      .done     (done[g]),
      .rd_en    (rd_en[g]),
      .rd_addr  (rd_addr[g]),
      .rd_data_a(rd_a),
      .rd_data_b(rd_b),
      .wr_en    (wr_en[g]),
      .wr_addr  (wr_addr[g]),
      .wr_data  (wr_data[g])
    );
  end

  // Synchronous-read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en[0]) begin
      rd_a <= mem_a[rd_addr[0]];
      rd_b <= mem_b[rd_addr[0]];
`ifdef NTT_PW_ACCUM_EN
      rd_c <= mem_c[rd_addr[0]];
`endif
    end
  end

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input bit acc);
    logic [63:0] r;
    r = (64'(a) * 64'(b)) % 64'(Q);
    if (acc) r = (r + 64'(c)) % 64'(Q);
    return 32'(r);
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
  endtask

  task automatic fill_random(input bit full, input bit acc);
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i]    = full ? $urandom : $urandom_range(Q - 1, 0);
      mem_b[i]    = full ? $urandom : $urandom_range(Q - 1, 0);
      mem_c[i]    = $urandom_range(Q - 1, 0);
      exp_data[i] = model(mem_a[i], mem_b[i], mem_c[i], acc);
    end
  endtask

  // Cycle c is the clock period after edge c-1; start is sampled at edge 0.
  task automatic run_pass(input int abort_at, input int rst_at, input bit noise, input bit acc);
    int wr_cnt [ND];
    int done_cnt [ND];
    int exp_wr, exp_done;
    bit live, e_rd, e_wr;
    for (int d = 0; d < ND; d++) begin
      wr_cnt[d]   = 0;
      done_cnt[d] = 0;
    end
    exp_wr   = 0;
    exp_done = 0;
    start = 1'b1;
`ifdef NTT_PW_ACCUM_EN
    accum_in = acc;
`else
    if (acc) $display("note: accumulate pass requested without NTT_PW_ACCUM_EN");
`endif
    @(posedge clk); #1;
    start = 1'b0;
`ifdef NTT_PW_ACCUM_EN
    accum_in = 1'b0;
`endif
    for (int c = 1; c <= int'(N) + 5; c++) begin
      abort = (c == abort_at);
      start = (noise && c >= 2 && c <= int'(N) + 3) || (c == abort_at);
      if (c == rst_at) rst = 1'b1;
      #1;
      live = !((abort_at > 0 && c > abort_at) || (rst_at > 0 && c >= rst_at));
      e_rd = live && c <= int'(N);
      e_wr = live && c >= 3 && c <= int'(N) + 2;
      if (e_wr) exp_wr++;
      if (live && c == int'(N) + 3) exp_done++;
      for (int d = 0; d < ND; d++) begin
        chk("busy", d, busy[d], live && c <= int'(N) + 3);
        chk("done", d, done[d], live && c == int'(N) + 3);
        chk("rd_en", d, rd_en[d], e_rd);
        chk("wr_en", d, wr_en[d], e_wr);
        if (e_rd) chk("rd_addr", d, rd_addr[d], 64'(c - 1));
        if (e_wr) begin
          chk("wr_addr", d, wr_addr[d], 64'(c - 3));
          chk("wr_data", d, wr_data[d], exp_data[c-3]);
        end
        if (c == rst_at) begin
          chk("rst_rd_addr", d, rd_addr[d], 0);
          chk("rst_wr_addr", d, wr_addr[d], 0);
          chk("rst_wr_data", d, wr_data[d], 0);
        end
        if (wr_en[d] === 1'b1) wr_cnt[d]++;
        if (done[d] === 1'b1) done_cnt[d]++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    abort = 1'b0;
    start = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("write_count", d, wr_cnt[d], exp_wr);
      chk("done_count", d, done_cnt[d], exp_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{32'd1,          32'd2,          32'd2};
    tbl[1] = '{32'd3328,       32'd3328,       32'd1};
    tbl[2] = '{32'd3328,       32'd2,          32'd3327};
    tbl[3] = '{32'd0,          32'd3328,       32'd0};
    tbl[4] = '{32'd1664,       32'd2,          32'd3328};
    tbl[5] = '{32'd1665,       32'd2,          32'd1};
    tbl[6] = '{32'd100,        32'd100,        32'd13};
    tbl[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd283};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("reset_busy", d, busy[d], 0);
      chk("reset_done", d, done[d], 0);
      chk("reset_rd_en", d, rd_en[d], 0);
      chk("reset_wr_en", d, wr_en[d], 0);
      chk("reset_rd_addr", d, rd_addr[d], 0);
      chk("reset_wr_addr", d, wr_addr[d], 0);
      chk("reset_wr_data", d, wr_data[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // A[i]=i+1, B[i]=2 gives C[i]=2i+2 in ascending order.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i]    = 32'(i + 1);
      mem_b[i]    = 32'd2;
      mem_c[i]    = 32'd0;
      exp_data[i] = 32'(2 * i + 2);
    end
    run_pass(0, 0, 1'b0, 1'b0);

    for (int k = 0; k < NV; k += int'(N)) begin
      for (int i = 0; i < int'(N); i++) begin
        mem_a[i]    = tbl[k+i].a;
        mem_b[i]    = tbl[k+i].b;
        mem_c[i]    = 32'd0;
        exp_data[i] = tbl[k+i].exp;
      end
      run_pass(0, 0, 1'b0, 1'b0);
    end

    // (Q-1)^2 = 1 mod Q at every index.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i]    = 32'd3328;
      mem_b[i]    = 32'd3328;
      mem_c[i]    = 32'd0;
      exp_data[i] = 32'd1;
    end
    run_pass(0, 0, 1'b0, 1'b0);

    // Abort (with start) in RUN cycle 2, then a full pass.
    fill_random(1'b0, 1'b0);
    run_pass(2, 0, 1'b0, 1'b0);
    fill_random(1'b0, 1'b0);
    run_pass(0, 0, 1'b0, 1'b0);

    // Abort in DRAIN drops the last write; abort in DONE changes nothing.
    fill_random(1'b0, 1'b0);
    run_pass(int'(N) + 1, 0, 1'b0, 1'b0);
    fill_random(1'b0, 1'b0);
    run_pass(int'(N) + 3, 0, 1'b0, 1'b0);

    // Reset in the second DRAIN cycle, then a pass with start held while busy.
    fill_random(1'b0, 1'b0);
    run_pass(0, int'(N) + 2, 1'b0, 1'b0);
    fill_random(1'b0, 1'b0);
    run_pass(0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random(r[0], 1'b0);
      run_pass(0, 0, 1'b0, 1'b0);
    end

`ifdef NTT_PW_ACCUM_EN
    // C_old=3000, A*B mod Q=500 accumulates to 171.
    for (int i = 0; i < int'(N); i++) begin
      mem_a[i]    = 32'd500;
      mem_b[i]    = 32'd1;
      mem_c[i]    = 32'd3000;
      exp_data[i] = 32'd171;
    end
    run_pass(0, 0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      fill_random(r[0], 1'b1);
      run_pass(0, 0, 1'b0, 1'b1);
    end
    fill_random(1'b0, 1'b0);
    run_pass(0, 0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
